// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
//
// Purpose: bundles the redirect, instruction-memory and fetch-output signals
// of the instruction fetch unit so they can be passed as a single port.
//
// Signals:
//   pc_sel          redirect request from the execute stage
//   branch_target   redirect address, sampled while pc_sel is high
//   ena             downstream IF/ID register accepts the head entry
//   imem_req        one-cycle request pulse to instruction memory
//   imem_addr       request address, valid while imem_req is high
//   imem_ack        response strobe from instruction memory
//   imem_rdata      instruction word, valid while imem_ack is high
//   out_instruction buffer-head instruction (zero when out_valid is low)
//   out_pc          buffer-head PC (zero when out_valid is low)
//   out_valid       fetch buffer holds at least one entry
//   misalign        one-cycle flag for a misaligned redirect target; present
//                   only when IF_FETCH_MISALIGN_CHECK_EN is defined
//
// Modports:
//   slave  - the fetch unit itself
//   master - the environment (execute stage, memory, decode stage)
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        pc_sel;
    logic [31:0] branch_target;
    logic        ena;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_valid;
`ifdef IF_FETCH_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    modport slave (
        input  pc_sel,
        input  branch_target,
        input  ena,
        input  imem_ack,
        input  imem_rdata,
`ifdef IF_FETCH_MISALIGN_CHECK_EN
        output misalign,
`endif
        output imem_req,
        output imem_addr,
        output out_instruction,
        output out_pc,
        output out_valid
    );

    modport master (
        output pc_sel,
        output branch_target,
        output ena,
        output imem_ack,
        output imem_rdata,
`ifdef IF_FETCH_MISALIGN_CHECK_EN
        input  misalign,
`endif
        input  imem_req,
        input  imem_addr,
        input  out_instruction,
        input  out_pc,
        input  out_valid
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Purpose: instruction fetch stage. Keeps a fetch PC, issues at most one
// instruction-memory request at a time, and queues returned instructions in
// a two-entry buffer whose head feeds the IF/ID register. A redirect from
// execute flushes the buffer, reloads the fetch PC and discards the response
// of any request still in flight.
//
// Parameters:
//   RESET_VECTOR  first fetch address after reset
//   BUF_DEPTH     fetch buffer entries; only 2 is supported
//
// Ports:
//   clk    single clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    if_fetch_unit_if.slave (redirect, memory and output signals)
//
// Configuration:
//   IF_FETCH_MISALIGN_CHECK_EN - when defined, redirect targets have bits
//   [1:0] cleared and bus.misalign pulses for one cycle after a redirect to
//   a misaligned target. When undefined the target is loaded unmodified and
//   the misalign signal does not exist.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BUF_DEPTH    = 2
) (
    input logic          clk,
    input logic          rst_n,
    if_fetch_unit_if.slave bus
);

    // IDLE: nothing in flight; WAIT: one request in flight, response kept;
    // DROP: one request in flight whose response must be thrown away.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [1:0] BUF_FULL = 2'(BUF_DEPTH);

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic [31:0] tail_instr_q, tail_instr_d;

    logic        out_valid;
    logic        issue;
    logic        push;
    logic        pop;
    logic [31:0] redirect_pc;

`ifdef IF_FETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    // Redirects always land on a word boundary; the dropped low bits are
    // reported through misalign one cycle later.
    assign redirect_pc = {bus.branch_target[31:2], 2'b00};
    assign misalign_d  = bus.pc_sel && (bus.branch_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign bus.misalign = misalign_q;
`else
    assign redirect_pc = bus.branch_target;
`endif

    assign out_valid = (count_q != 2'd0);

    // A pop needs a visible head and an accepting IF/ID register; a redirect
    // overrides it because the whole buffer is flushed anyway.
    assign pop = out_valid && bus.ena && !bus.pc_sel;

    // State register for the request FSM, the fetch PC and the request
    // outputs, which are registered so memory sees clean pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fpc_q       <= RESET_VECTOR;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    // Request FSM. A request is only started from IDLE with a free buffer
    // slot, so buffered entries plus the one in flight never exceed the
    // buffer depth and a response always has somewhere to go. The response
    // cycle itself never starts a new request; IDLE does that next cycle.
    // imem_addr_q keeps the in-flight address, which becomes the entry PC.
    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        imem_req_d  = 1'b0;
        imem_addr_d = imem_addr_q;
        issue       = 1'b0;
        push        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!bus.pc_sel && (count_q < BUF_FULL)) begin
                    issue   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.imem_ack) begin
                    push    = !bus.pc_sel;
                    state_d = ST_IDLE;
                end else if (bus.pc_sel) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (bus.imem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue) begin
            imem_req_d  = 1'b1;
            imem_addr_d = fpc_q;
            fpc_d       = fpc_q + 32'd4;
        end

        // A redirect wins over everything else the fetch PC might do.
        if (bus.pc_sel) begin
            fpc_d = redirect_pc;
        end
    end

    // Fetch buffer storage: head entry drives the outputs, tail entry is the
    // second slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= 2'd0;
            head_pc_q    <= 32'h0;
            head_instr_q <= 32'h0;
            tail_pc_q    <= 32'h0;
            tail_instr_q <= 32'h0;
        end else begin
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
        end
    end

    // Buffer update. A pop shifts the tail into the head; a push then lands
    // in whichever slot is first free after that shift. A push into a full
    // buffer cannot occur because requests are throttled by the FSM.
    always_comb begin
        count_d      = count_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;

        if (bus.pc_sel) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                head_pc_d    = tail_pc_q;
                head_instr_d = tail_instr_q;
            end
            if (push) begin
                if ((count_q == 2'd0) || (pop && (count_q == 2'd1))) begin
                    head_pc_d    = imem_addr_q;
                    head_instr_d = bus.imem_rdata;
                end else begin
                    tail_pc_d    = imem_addr_q;
                    tail_instr_d = bus.imem_rdata;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.imem_req        = imem_req_q;
    assign bus.imem_addr       = imem_addr_q;
    assign bus.out_valid       = out_valid;
    assign bus.out_pc          = out_valid ? head_pc_q : 32'h0;
    assign bus.out_instruction = out_valid ? head_instr_q : 32'h0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Purpose: self-checking bench for if_fetch_unit. A memory responder answers
// each request after a programmable delay with a word derived from its
// address; a monitor keeps the expected stream of fetched entries as a
// queue and compares the buffer head, request addresses and (when
// IF_FETCH_MISALIGN_CHECK_EN is defined) the misalign flag every cycle.
// Scenario tasks add their own directed comparisons.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic clk;
    logic rst_n = 1'b1;

    if_fetch_unit_if fetch_if();

    if_fetch_unit #(
        .RESET_VECTOR(RV),
        .BUF_DEPTH   (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (fetch_if)
    );

    int          total = 0;
    int          bad   = 0;

    entry_t      exp_q[$];
    logic        pending   = 1'b0;
    logic        kept      = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] next_addr = RV;
    logic        prev_mis  = 1'b0;

    int          ack_min   = 1;
    int          ack_max   = 1;
    int          ack_cnt   = 0;
    logic [31:0] resp_addr = 32'h0;
    logic        stray_ack = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] target_of(input logic [31:0] t);
`ifdef IF_FETCH_MISALIGN_CHECK_EN
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    // Memory responder: answers each request after ack_min..ack_max cycles.
    initial begin
        fetch_if.imem_ack   = 1'b0;
        fetch_if.imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            fetch_if.imem_ack   = 1'b0;
            fetch_if.imem_rdata = $urandom;
            if (!rst_n) begin
                ack_cnt = 0;
            end else if (stray_ack) begin
                fetch_if.imem_ack = 1'b1;
            end else if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    fetch_if.imem_ack   = 1'b1;
                    fetch_if.imem_rdata = mem_word(resp_addr);
                end
            end
            if (rst_n && fetch_if.imem_req) begin
                ack_cnt   = $urandom_range(ack_max, ack_min);
                resp_addr = fetch_if.imem_addr;
            end
        end
    end

    // Reference model and monitor: expected entries are a queue filled by
    // kept responses, emptied by accepted pops and flushed by redirects.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                pending   = 1'b0;
                kept      = 1'b0;
                next_addr = RV;
                prev_mis  = 1'b0;
            end else begin
                total++;
                if (fetch_if.out_valid !== (exp_q.size() != 0)) begin
                    bad++;
                    $display("[TB] FAIL out_valid: got %b expected %b at %0t",
                             fetch_if.out_valid, exp_q.size() != 0, $time);
                end
                if (exp_q.size() != 0) begin
                    total++;
                    if (fetch_if.out_pc !== exp_q[0].pc) begin
                        bad++;
                        $display("[TB] FAIL out_pc: got %h expected %h at %0t",
                                 fetch_if.out_pc, exp_q[0].pc, $time);
                    end
                    total++;
                    if (fetch_if.out_instruction !== exp_q[0].instr) begin
                        bad++;
                        $display("[TB] FAIL out_instruction: got %h expected %h at %0t",
                                 fetch_if.out_instruction, exp_q[0].instr, $time);
                    end
                end else begin
                    total++;
                    if (fetch_if.out_pc !== 32'h0 || fetch_if.out_instruction !== 32'h0) begin
                        bad++;
                        $display("[TB] FAIL empty_outputs: got pc=%h instr=%h expected 0 at %0t",
                                 fetch_if.out_pc, fetch_if.out_instruction, $time);
                    end
                end

                if (fetch_if.imem_req) begin
                    total++;
                    if (fetch_if.imem_addr !== next_addr) begin
                        bad++;
                        $display("[TB] FAIL imem_addr: got %h expected %h at %0t",
                                 fetch_if.imem_addr, next_addr, $time);
                    end
                    total++;
                    if (pending || exp_q.size() > 1) begin
                        bad++;
                        $display("[TB] FAIL req_throttle: got outstanding=%0d buffered=%0d expected 0 and <=1 at %0t",
                                 pending, exp_q.size(), $time);
                    end
                    pend_addr = fetch_if.imem_addr;
                    pending   = 1'b1;
                    kept      = 1'b1;
                    next_addr = next_addr + 32'd4;
                end

`ifdef IF_FETCH_MISALIGN_CHECK_EN
                total++;
                if (fetch_if.misalign !== prev_mis) begin
                    bad++;
                    $display("[TB] FAIL misalign: got %b expected %b at %0t",
                             fetch_if.misalign, prev_mis, $time);
                end
                prev_mis = fetch_if.pc_sel && (fetch_if.branch_target[1:0] != 2'b00);
`endif

                if (exp_q.size() != 0 && fetch_if.ena && !fetch_if.pc_sel) begin
                    void'(exp_q.pop_front());
                end
                if (fetch_if.imem_ack && pending) begin
                    if (kept && !fetch_if.pc_sel) begin
                        exp_q.push_back({pend_addr, mem_word(pend_addr)});
                    end
                    pending = 1'b0;
                end
                if (fetch_if.pc_sel) begin
                    exp_q.delete();
                    kept      = 1'b0;
                    next_addr = target_of(fetch_if.branch_target);
                end
            end
        end
    end

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (fetch_if.imem_req) seen = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        @(posedge clk);
        #1;
        fetch_if.pc_sel        = 1'b1;
        fetch_if.branch_target = target;
        @(posedge clk);
        #1;
        fetch_if.pc_sel        = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (fetch_if.imem_req !== 1'b0 || fetch_if.out_valid !== 1'b0 ||
            fetch_if.out_pc !== 32'h0 || fetch_if.out_instruction !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got req=%b valid=%b pc=%h instr=%h expected all 0",
                     fetch_if.imem_req, fetch_if.out_valid, fetch_if.out_pc, fetch_if.out_instruction);
        end
`ifdef IF_FETCH_MISALIGN_CHECK_EN
        total++;
        if (fetch_if.misalign !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_misalign: got %b expected 0", fetch_if.misalign);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (fetch_if.imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL req_before_edge: got %b expected 0", fetch_if.imem_req);
        end
        @(negedge clk);
        total++;
        if (fetch_if.imem_req !== 1'b1 || fetch_if.imem_addr !== RV) begin
            bad++;
            $display("[TB] FAIL first_req: got req=%b addr=%h expected req=1 addr=%h",
                     fetch_if.imem_req, fetch_if.imem_addr, RV);
        end
    endtask

    task automatic test_reset_midwait();
        bit seen;
        ack_min = 3;
        ack_max = 3;
        wait_req(seen);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (!seen || fetch_if.imem_req !== 1'b0 || fetch_if.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset: got seen=%b req=%b valid=%b expected seen=1 req=0 valid=0",
                     seen, fetch_if.imem_req, fetch_if.out_valid);
        end
        ack_min = 1;
        ack_max = 1;
        @(negedge clk);
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        total++;
        if (fetch_if.out_valid !== 1'b0 || fetch_if.imem_req !== 1'b1 || fetch_if.imem_addr !== RV) begin
            bad++;
            $display("[TB] FAIL stray_ack: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=%h",
                     fetch_if.out_valid, fetch_if.imem_req, fetch_if.imem_addr, RV);
        end
    endtask

    task automatic test_sequential();
        bit seen;
        ack_min = 1;
        ack_max = 1;
        fetch_if.ena = 1'b1;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            wait_req(seen);
            total++;
            if (!seen || fetch_if.imem_addr !== RV + 32'(i * 4)) begin
                bad++;
                $display("[TB] FAIL seq_addr[%0d]: got seen=%b addr=%h expected %h",
                         i, seen, fetch_if.imem_addr, RV + 32'(i * 4));
            end
        end
    endtask

    task automatic test_stall();
        int          reqs;
        logic [31:0] popped[$];
        reqs = 0;
        fetch_if.ena = 1'b0;
        apply_reset();
        repeat (14) begin
            @(negedge clk);
            if (fetch_if.imem_req) reqs++;
        end
        total++;
        if (reqs != 2 || fetch_if.out_valid !== 1'b1 || fetch_if.out_pc !== RV) begin
            bad++;
            $display("[TB] FAIL stall_fill: got reqs=%0d valid=%b pc=%h expected 2 1 %h",
                     reqs, fetch_if.out_valid, fetch_if.out_pc, RV);
        end
        @(posedge clk);
        #1;
        fetch_if.ena = 1'b1;
        for (int i = 0; i < 20 && popped.size() < 4; i++) begin
            @(negedge clk);
            if (fetch_if.out_valid) popped.push_back(fetch_if.out_pc);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= popped.size() || popped[i] !== RV + 32'(i * 4)) begin
                bad++;
                $display("[TB] FAIL drain[%0d]: got %h expected %h", i,
                         (i < popped.size()) ? popped[i] : 32'hxxxx_xxxx, RV + 32'(i * 4));
            end
        end
    endtask

    task automatic test_redirect_wait();
        bit seen;
        ack_min = 3;
        ack_max = 3;
        fetch_if.ena = 1'b1;
        wait_req(seen);
        pulse_redirect(32'h0000_0100);
        ack_min = 1;
        ack_max = 1;
        wait_req(seen);
        total++;
        if (!seen || fetch_if.imem_addr !== 32'h0000_0100) begin
            bad++;
            $display("[TB] FAIL redirect_wait_addr: got seen=%b addr=%h expected 00000100",
                     seen, fetch_if.imem_addr);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (fetch_if.out_valid) seen = 1'b1;
        end
        total++;
        if (!seen || fetch_if.out_pc !== 32'h0000_0100 ||
            fetch_if.out_instruction !== mem_word(32'h0000_0100)) begin
            bad++;
            $display("[TB] FAIL redirect_wait_out: got seen=%b pc=%h instr=%h expected 00000100 %h",
                     seen, fetch_if.out_pc, fetch_if.out_instruction, mem_word(32'h0000_0100));
        end
    endtask

    task automatic test_redirect_ack();
        bit seen;
        ack_min = 1;
        ack_max = 1;
        wait_req(seen);
        pulse_redirect(32'h0000_0200);
        @(negedge clk);
        total++;
        if (!seen || fetch_if.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL redirect_ack_valid: got seen=%b valid=%b expected seen=1 valid=0",
                     seen, fetch_if.out_valid);
        end
        wait_req(seen);
        total++;
        if (!seen || fetch_if.imem_addr !== 32'h0000_0200) begin
            bad++;
            $display("[TB] FAIL redirect_ack_addr: got seen=%b addr=%h expected 00000200",
                     seen, fetch_if.imem_addr);
        end
    endtask

    task automatic test_wrap();
        bit          seen;
        logic [31:0] want;
        ack_min = 1;
        ack_max = 1;
        pulse_redirect(32'hFFFF_FFF8);
        want = 32'hFFFF_FFF8;
        for (int i = 0; i < 3; i++) begin
            wait_req(seen);
            total++;
            if (!seen || fetch_if.imem_addr !== want) begin
                bad++;
                $display("[TB] FAIL wrap_addr[%0d]: got seen=%b addr=%h expected %h",
                         i, seen, fetch_if.imem_addr, want);
            end
            want = want + 32'd4;
        end
    endtask

`ifdef IF_FETCH_MISALIGN_CHECK_EN
    task automatic test_misalign();
        bit seen;
        pulse_redirect(32'h0000_0102);
        @(negedge clk);
        total++;
        if (fetch_if.misalign !== 1'b1) begin
            bad++;
            $display("[TB] FAIL misalign_pulse: got %b expected 1", fetch_if.misalign);
        end
        wait_req(seen);
        total++;
        if (!seen || fetch_if.imem_addr !== 32'h0000_0100) begin
            bad++;
            $display("[TB] FAIL misalign_addr: got seen=%b addr=%h expected 00000100",
                     seen, fetch_if.imem_addr);
        end
    endtask
`endif

    task automatic test_random();
        ack_min = 1;
        ack_max = 4;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            fetch_if.ena           = ($urandom_range(0, 3) != 0);
            fetch_if.pc_sel        = ($urandom_range(0, 15) == 0);
            fetch_if.branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : $urandom;
        end
        @(posedge clk);
        #1;
        fetch_if.pc_sel = 1'b0;
        fetch_if.ena    = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        fetch_if.pc_sel        = 1'b0;
        fetch_if.branch_target = 32'h0;
        fetch_if.ena           = 1'b1;
        test_reset();
        test_reset_midwait();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap();
`ifdef IF_FETCH_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
